// File: rtl/median_stream_if.sv
// Sample/result bundle for median_stream.
//   master: producer side (drives CLR, DI, DSI and RANK when present; observes results)
//   slave : filter side (takes samples, drives DO, DSO, BUSY)
// Signals:
//   CLR  - synchronous abort of the partial window
//   DI   - input sample, taken when DSI=1
//   DSI  - per-cycle sample valid
//   RANK - selected output rank, 0=min (only when RANK_SEL_EN is defined)
//   DO   - registered result, holds until the next result
//   DSO  - one-cycle result strobe
//   BUSY - a window is partially filled
// Optional feature macro: RANK_SEL_EN.
interface median_stream_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned N     = 9
);
  localparam int unsigned CW = $clog2(N + 1);

  logic             CLR;
  logic [WIDTH-1:0] DI;
  logic             DSI;
`ifdef RANK_SEL_EN
  logic [CW-1:0]    RANK;
`endif
  logic [WIDTH-1:0] DO;
  logic             DSO;
  logic             BUSY;

`ifdef RANK_SEL_EN
  modport master (output CLR, DI, DSI, RANK, input DO, DSO, BUSY);
  modport slave  (input CLR, DI, DSI, RANK, output DO, DSO, BUSY);
`else
  modport master (output CLR, DI, DSI, input DO, DSO, BUSY);
  modport slave  (input CLR, DI, DSI, output DO, DSO, BUSY);
`endif
endinterface

// File: rtl/median_stream.sv
// Streaming rank-order filter. Collects N unsigned samples per window into an
// insertion-sorted array and, on the edge that accepts the Nth sample, registers
// the selected rank into DO with a one-cycle DSO strobe.
// Ports:
//   CLK  - clock, rising edge
//   nRST - asynchronous active-low reset
//   bus  - median_stream_if.slave (CLR, DI, DSI, [RANK] in; DO, DSO, BUSY out)
// Parameters: WIDTH sample width, N odd window size in 3..31.
// Optional feature macro: RANK_SEL_EN -- when defined the output rank comes from
// bus.RANK (clamped to N-1); otherwise the true median (N-1)/2 is emitted.
module median_stream #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned N     = 9
) (
  input  logic             CLK,
  input  logic             nRST,
  median_stream_if.slave   bus
);
  localparam int unsigned CW     = $clog2(N + 1);
  localparam int unsigned Median = (N - 1) / 2;

  if ((N < 3) || (N > 31) || ((N % 2) == 0)) begin : g_bad_n
    $error("median_stream: N must be odd and in 3..31");
  end
  if (WIDTH < 1) begin : g_bad_width
    $error("median_stream: WIDTH must be at least 1");
  end

  typedef logic [WIDTH-1:0] sample_t;

  // State registers
  sample_t       r_arr [N];
  logic [CW-1:0] r_cnt;
  sample_t       r_do;
  logic          r_dso;

  // Next-state wires
  sample_t       w_ins [N];
  logic [N-1:0]  w_keep;
  logic [CW-1:0] w_sel;
  logic [CW-1:0] w_cnt_d;
  sample_t       w_do_d;
  logic          w_dso_d;
  logic          w_arr_we;
  logic          w_last;

  // Insertion: an occupied slot keeps its value when it is <= DI (ties stay
  // ahead of the new sample). The array is ascending, so w_keep is a run of
  // ones followed by zeros; DI lands at the first zero and the rest shift up.
  // Slots at index >= count never keep, so stale contents cannot leak in.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      w_keep[i] = (CW'(i) < r_cnt) && !(r_arr[i] > bus.DI);
    end
    w_ins[0] = w_keep[0] ? r_arr[0] : bus.DI;
    for (int i = 1; i < N; i++) begin
      if (w_keep[i]) begin
        w_ins[i] = r_arr[i];
      end else if (w_keep[i-1]) begin
        w_ins[i] = bus.DI;
      end else begin
        w_ins[i] = r_arr[i-1];
      end
    end
  end

`ifdef RANK_SEL_EN
  assign w_sel = (bus.RANK >= CW'(N)) ? CW'(N - 1) : bus.RANK;
`else
  assign w_sel = CW'(Median);
`endif

  assign w_last = (r_cnt == CW'(N - 1));

  // Fill-count sequencing: IDLE when count is 0, FILL otherwise.
  always_comb begin
    w_cnt_d  = r_cnt;
    w_do_d   = r_do;
    w_dso_d  = 1'b0;
    w_arr_we = 1'b0;
    if (bus.CLR) begin
      // Abort wins over any sample or completion in the same cycle
      w_cnt_d = '0;
    end else if (bus.DSI) begin
      w_arr_we = 1'b1;
      if (w_last) begin
        w_cnt_d = '0;
        w_do_d  = w_ins[w_sel];
        w_dso_d = 1'b1;
      end else begin
        w_cnt_d = r_cnt + CW'(1);
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < N; i++) begin
        r_arr[i] <= '0;
      end
      r_cnt <= '0;
      r_do  <= '0;
      r_dso <= 1'b0;
    end else begin
      if (w_arr_we) begin
        for (int i = 0; i < N; i++) begin
          r_arr[i] <= w_ins[i];
        end
      end
      r_cnt <= w_cnt_d;
      r_do  <= w_do_d;
      r_dso <= w_dso_d;
    end
  end

  assign bus.DO   = r_do;
  assign bus.DSO  = r_dso;
  assign bus.BUSY = (r_cnt != '0);

endmodule

// File: tb/tb_median_stream.sv
// Bench for median_stream: directed windows plus random traffic, checked by a
// scoreboard fed from a sort-and-pick reference model.
module tb_median_stream;
  localparam int unsigned WIDTH = 8;
  localparam int unsigned N     = 9;
  localparam int unsigned CW    = $clog2(N + 1);

  logic CLK  = 1'b0;
  logic nRST = 1'b0;
  always #5 CLK = ~CLK;

  median_stream_if #(.WIDTH(WIDTH), .N(N)) bus ();

  median_stream #(.WIDTH(WIDTH), .N(N)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus)
  );

  typedef struct {
    int val;
    int cyc;
  } exp_t;

  exp_t             sb[$];
  logic [WIDTH-1:0] win[$];
  int               cyc = 0;
  logic             exp_busy = 1'b0;
  int               last_do = 0;
  int               checks = 0;
  int               failures = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Drives one cycle of inputs at the falling edge and advances the model to
  // the state expected after the following rising edge.
  task automatic step(input logic dsi, input int di, input logic clr, input int rank);
    logic [WIDTH-1:0] sorted[$];
    int               sel;
    @(negedge CLK);
    bus.DSI = dsi;
    bus.DI  = WIDTH'(di);
    bus.CLR = clr;
`ifdef RANK_SEL_EN
    bus.RANK = CW'(rank);
    sel = (rank >= int'(N)) ? int'(N) - 1 : rank;
`else
    sel = (int'(N) - 1) / 2;
`endif
    if (clr) begin
      win.delete();
    end else if (dsi) begin
      win.push_back(WIDTH'(di));
      if (win.size() == int'(N)) begin
        sorted = win;
        sorted.sort();
        sb.push_back('{val: int'(sorted[sel]), cyc: cyc + 1});
        win.delete();
      end
    end
    exp_busy = (win.size() != 0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 0, 1'b0, 0);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    nRST    = 1'b0;
    bus.DSI = 1'b0;
    bus.CLR = 1'b0;
    win.delete();
    exp_busy = 1'b0;
    repeat (2) @(negedge CLK);
    nRST = 1'b1;
  endtask

  // Monitor: samples 1 time unit after each rising edge.
  initial begin
    forever begin
      @(posedge CLK);
      #1;
      check("busy", int'(bus.BUSY), int'(exp_busy));
      if (!nRST) begin
        check("rst_do", int'(bus.DO), 0);
        check("rst_dso", int'(bus.DSO), 0);
        last_do = 0;
      end else if (bus.DSO) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_dso: got DSO=1 DO=%0d, required DSO=0 (cycle %0d)",
                   bus.DO, cyc);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("result_do", int'(bus.DO), e.val);
          check("result_cycle", cyc, e.cyc);
          last_do = e.val;
        end
      end else begin
        check("do_hold", int'(bus.DO), last_do);
        if (sb.size() != 0) check("dso_not_late", int'(cyc < sb[0].cyc), 1);
      end
    end
  end

  int w_b2[9]  = '{90, 10, 80, 20, 70, 30, 60, 40, 50};
  int w_pi[9]  = '{3, 1, 4, 1, 5, 9, 2, 6, 5};
  int w_ext[9] = '{0, 255, 17, 200, 3, 128, 64, 99, 1};

  initial begin
    bus.DSI = 1'b0;
    bus.DI  = '0;
    bus.CLR = 1'b0;
`ifdef RANK_SEL_EN
    bus.RANK = '0;
`endif
    nRST = 1'b0;
    repeat (2) @(negedge CLK);
    nRST = 1'b1;
    idle(2);

    // Descending window, median 5
    for (int v = 9; v >= 1; v--) step(1'b1, v, 1'b0, 4);
    idle(3);

    // All-equal samples with gaps
    for (int i = 0; i < 9; i++) begin
      step(1'b1, 7, 1'b0, 4);
      idle(2);
    end
    idle(2);

    // Back-to-back windows
    for (int v = 1; v <= 9; v++) step(1'b1, v, 1'b0, 4);
    for (int i = 0; i < 9; i++) step(1'b1, w_b2[i], 1'b0, 4);
    idle(2);

    // Abort after 4 samples, then a full window
    for (int i = 0; i < 4; i++) step(1'b1, 200 + i, 1'b0, 4);
    step(1'b1, 250, 1'b1, 4);
    for (int i = 0; i < 9; i++) step(1'b1, w_pi[i], 1'b0, 4);
    idle(2);

    // CLR coincident with the completing sample
    for (int i = 0; i < 8; i++) step(1'b1, 10 * i, 1'b0, 4);
    step(1'b1, 33, 1'b1, 4);
    idle(2);

    // Reset mid-window, then extremes
    for (int i = 0; i < 5; i++) step(1'b1, 240 - i, 1'b0, 4);
    do_reset();
    for (int i = 0; i < 9; i++) step(1'b1, w_ext[i], 1'b0, 4);
    idle(2);

`ifdef RANK_SEL_EN
    for (int r = 0; r < 3; r++) begin
      int rk;
      rk = (r == 0) ? 0 : ((r == 1) ? 8 : 12);
      for (int v = 1; v <= 9; v++) step(1'b1, v, 1'b0, rk);
      idle(1);
    end
`endif

    // Random traffic, with tie-heavy values part of the time
    for (int i = 0; i < 600; i++) begin
      logic dsi, clr;
      int   di;
      dsi = ($urandom_range(0, 9) < 7);
      clr = ($urandom_range(0, 39) == 0);
      di  = (i < 300) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 3));
      step(dsi, di, clr, int'($urandom_range(0, 15)));
    end
    idle(3);

    check("scoreboard_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
